// File: rtl/riscv_trace_buf_if.sv
// riscv_trace_buf_if
// Drain-side bundle of the trace buffer: the head record plus its
// valid/ready handshake.
//   master (trace buffer): drives tr_valid, tr_kind, tr_tag, tr_data, tr_ts;
//                          samples tr_ready
//   slave  (consumer)    : samples the record; drives tr_ready
// Parameters: DATA_W record data width, TAG_W tag width, TS_W timestamp width.
interface riscv_trace_buf_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 9,
    parameter int TS_W   = 16
);
    logic              tr_valid;
    logic              tr_ready;
    logic [1:0]        tr_kind;
    logic [TAG_W-1:0]  tr_tag;
    logic [DATA_W-1:0] tr_data;
    logic [TS_W-1:0]   tr_ts;

    modport master (
        output tr_valid, tr_kind, tr_tag, tr_data, tr_ts,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_kind, tr_tag, tr_data, tr_ts,
        output tr_ready
    );
endinterface

// File: rtl/riscv_trace_buf.sv
// riscv_trace_buf
// Execution-trace capture for the single-clock RISC-V core. Every cycle the
// writeback and data-memory taps are sampled; qualifying events (memory
// access first, then register write) are packed into records and pushed
// into a DEPTH-entry first-word-fall-through FIFO, up to two per cycle.
// Events that find no free slot are dropped and counted.
//
// Ports:
//   clk, reset      core clock, asynchronous active-high reset
//   clear           synchronous flush of FIFO, timestamp and drop accounting
//   mode[1:0]       capture filter: 00 off, 01 reg, 10 mem, 11 both
//   reg_write_sig, reg_num, reg_data        register-file writeback tap
//   wr, rd, addr, wr_data, rd_data          data-memory tap
//   tr              riscv_trace_buf_if.master: head record + valid/ready
//   level           FIFO occupancy (0..DEPTH)
//   overflow        sticky, set once any event has been dropped
//   drop_cnt        dropped-event count, saturating at 255
//
// Build option: define RISCV_TRACE_TS_EN to include the timestamp counter
// and per-entry timestamp storage; otherwise tr_ts is constant zero.
module riscv_trace_buf #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 9,
    parameter  int DEPTH  = 16,
    parameter  int TS_W   = 16,
    localparam int TAG_W  = (ADDR_W > 5) ? ADDR_W : 5,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic              reg_write_sig,
    input  logic [4:0]        reg_num,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    riscv_trace_buf_if.master tr,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]        kind;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rec_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0] level_reg, level_next;
    logic             overflow_reg, overflow_next;
    logic [7:0]       drop_cnt_reg, drop_cnt_next;

    rec_t             fifo_mem [DEPTH];

    // ------------------------------------------------------------------
    // Event qualification and record formation
    // ------------------------------------------------------------------
    logic mem_ev, reg_ev;
    rec_t mem_rec, reg_rec, rec0, rec1;

    assign mem_ev = (wr || rd) && mode[1];
    assign reg_ev = reg_write_sig && (reg_num != 5'd0) && mode[0];

    // A simultaneous wr and rd is recorded as a single write.
    assign mem_rec.kind = wr ? 2'b10 : 2'b11;
    assign mem_rec.tag  = TAG_W'(addr);
    assign mem_rec.data = wr ? wr_data : rd_data;

    assign reg_rec.kind = 2'b01;
    assign reg_rec.tag  = TAG_W'(reg_num);
    assign reg_rec.data = reg_data;

    // Slot 0 takes the memory event if there is one, so memory always
    // precedes the register write of the same cycle.
    assign rec0 = mem_ev ? mem_rec : reg_rec;
    assign rec1 = reg_rec;

    // ------------------------------------------------------------------
    // Push / pop / drop arithmetic
    // ------------------------------------------------------------------
    logic             tr_valid_int;
    logic             pop;
    logic [1:0]       n_ev, n_push, n_drop;
    logic [LVL_W:0]   free_slots;
    logic             push0, push1;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [8:0]       drop_sum;

    assign tr_valid_int = (level_reg != '0);
    assign pop          = tr_valid_int && tr.tr_ready;

    assign n_ev = {1'b0, mem_ev} + {1'b0, reg_ev};

    // A pop this cycle frees its slot for a same-cycle push.
    assign free_slots = (LVL_W+1)'(DEPTH) - {1'b0, level_reg} + {{LVL_W{1'b0}}, pop};

    assign push0 = !clear && (n_ev != 2'd0) && (free_slots != '0);
    assign push1 = !clear && (n_ev == 2'd2) && (free_slots >= (LVL_W+1)'(2));

    assign n_push   = {1'b0, push0} + {1'b0, push1};
    assign n_drop   = n_ev - n_push;
    assign drop_sum = {1'b0, drop_cnt_reg} + {7'b0, n_drop};

    assign wr_ptr_p1 = wr_ptr_reg + PTR_W'(1);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (clear) begin
            // Events in the clear cycle are discarded without being counted.
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            level_next    = '0;
            overflow_next = 1'b0;
            drop_cnt_next = 8'd0;
        end else begin
            wr_ptr_next   = wr_ptr_reg + PTR_W'(n_push);
            rd_ptr_next   = rd_ptr_reg + PTR_W'(pop);
            level_next    = level_reg + LVL_W'(n_push) - LVL_W'(pop);
            overflow_next = overflow_reg | (n_drop != 2'd0);
            drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage: two write ports (wr_ptr and wr_ptr+1), one async read at
    // the head. Entries need no reset; the outputs are masked by tr_valid.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] sel0, sel1;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign sel0[gi] = push0 && (wr_ptr_reg == PTR_W'(gi));
            assign sel1[gi] = push1 && (wr_ptr_p1  == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (sel0[i]) begin
                fifo_mem[i] <= rec0;
            end else if (sel1[i]) begin
                fifo_mem[i] <= rec1;
            end
        end
    end

    rec_t head;
    assign head = fifo_mem[rd_ptr_reg];

    assign tr.tr_valid = tr_valid_int;
    assign tr.tr_kind  = tr_valid_int ? head.kind : 2'b00;
    assign tr.tr_tag   = tr_valid_int ? head.tag  : '0;
    assign tr.tr_data  = tr_valid_int ? head.data : '0;

    // ------------------------------------------------------------------
    // Timestamp
    // ------------------------------------------------------------------
`ifdef RISCV_TRACE_TS_EN
    logic [TS_W-1:0] ts_reg, ts_next;
    logic [TS_W-1:0] ts_mem [DEPTH];

    // Held at zero while capture is off so a re-enabled trace restarts at 0.
    assign ts_next = (clear || (mode == 2'b00)) ? '0 : ts_reg + TS_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_next;
        end
    end

    // Both records of a cycle carry the timestamp of that cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (sel0[i] || sel1[i]) begin
                ts_mem[i] <= ts_reg;
            end
        end
    end

    assign tr.tr_ts = tr_valid_int ? ts_mem[rd_ptr_reg] : '0;
`else
    assign tr.tr_ts = {TS_W{1'b0}};
`endif

    assign level    = level_reg;
    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule
